// File: rtl/axi4_lite_slave_mem_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and default bus widths.
package axi4_lite_Defs;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_slave_mem_bytemem.sv
// DEPTH x DATA_WIDTH storage: one byte-strobed write port, one registered read port.
module axi4_lite_bytemem import axi4_lite_Defs::*; #(
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int DEPTH      = 256,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic                  re,
    input  logic                  rzero,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= rzero ? '0 : mem[raddr];
    end

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave memory with independent read/write FSMs and out-of-order AW/W capture.
// Define AXI4_LITE_SLVERR_EN to range-check addresses and answer SLVERR instead of wrapping.
module axi4_lite_slave_mem import axi4_lite_Defs::*; #(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int DEPTH      = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(DEPTH);

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic                  aw_hs, w_hs, ar_hs, wr_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_oor, rd_oor;
    logic                  unused_addr;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // The edge that completes the AW+W pair, whichever half arrived first.
    assign wr_fire = !ARESET && ((aw_hs && w_hs) ||
                                 (aw_hs && wr_state == WR_HAVE_W) ||
                                 (w_hs && wr_state == WR_HAVE_AW));

    assign wr_addr = (wr_state == WR_HAVE_AW) ? aw_addr_q : AWADDR;
    assign wr_data = (wr_state == WR_HAVE_W)  ? w_data_q  : WDATA;
    assign wr_strb = (wr_state == WR_HAVE_W)  ? w_strb_q  : WSTRB;

`ifdef AXI4_LITE_SLVERR_EN
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH * STRB_W);
    assign wr_oor = {1'b0, wr_addr} >= LIMIT;
    assign rd_oor = {1'b0, ARADDR} >= LIMIT;
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    // Byte-offset bits (and upper bits when wrapping) do not select a word.
    assign unused_addr = ^{wr_addr, ARADDR};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state  <= WR_IDLE;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (wr_fire) begin
            wr_state <= WR_RESP;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b1;
            BRESP    <= wr_oor ? SLVERR : OKAY;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        wr_state  <= WR_HAVE_AW;
                        aw_addr_q <= AWADDR;
                        AWREADY   <= 1'b0;
                        WREADY    <= 1'b1;
                    end else if (w_hs) begin
                        wr_state <= WR_HAVE_W;
                        w_data_q <= WDATA;
                        w_strb_q <= WSTRB;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b0;
                    end else begin
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        wr_state <= WR_IDLE;
                        BVALID   <= 1'b0;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state <= RD_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RRESP    <= OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state <= RD_DATA;
                        ARREADY  <= 1'b0;
                        RVALID   <= 1'b1;
                        RRESP    <= rd_oor ? SLVERR : OKAY;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (RREADY) begin
                        rd_state <= RD_IDLE;
                        RVALID   <= 1'b0;
                        ARREADY  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read and write share an edge on collision; the registered read sees the old word.
    axi4_lite_bytemem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (wr_fire && !wr_oor),
        .waddr (wr_addr[ADDR_LSB +: IDX_W]),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .re    (ar_hs && !ARESET),
        .rzero (rd_oor),
        .raddr (ARADDR[ADDR_LSB +: IDX_W]),
        .rdata (RDATA)
    );

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed bench for axi4_lite_slave_mem (32-bit address/data, DEPTH 256).
module tb_axi4_lite_slave_mem;

    logic        ACLK, ARESET;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    int compared   = 0;
    int mismatched = 0;

    axi4_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] exp_resp, input string tag);
        chk({tag, "_rdy"}, {AWREADY, WREADY}, 2'b11);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk({tag, "_b"}, {BVALID, BRESP}, {1'b1, exp_resp});
        tick();
        chk({tag, "_bdone"}, {BVALID, AWREADY, WREADY}, 3'b011);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp,
                      input string tag);
        chk({tag, "_rdy"}, ARREADY, 1'b1);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        tick();
        ARVALID = 1'b0;
        chk({tag, "_r"}, {RVALID, RRESP, RDATA}, {1'b1, exp_resp, exp_d});
        tick();
        chk({tag, "_rdone"}, {RVALID, ARREADY}, 2'b01);
    endtask

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        tick(); tick();
        chk("reset_outs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}, '0);
        ARESET = 1'b0;
        tick();
        chk("ready_after_reset", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);

        // Simultaneous AW+W, then read back.
        wr(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, "wr_10");
        rd(32'h10, 32'hDEADBEEF, 2'b00, "rd_10");

        // W arrives three cycles ahead of AW.
        WDATA = 32'h11223344; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("w_first_state", {AWREADY, WREADY, BVALID}, 3'b100);
        tick(); tick();
        chk("w_first_hold", {AWREADY, WREADY, BVALID}, 3'b100);
        AWADDR = 32'h20; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("aw_late_b", {BVALID, BRESP}, 3'b100);
        tick();
        chk("aw_late_bdone", {BVALID, AWREADY, WREADY}, 3'b011);
        rd(32'h20, 32'h11223344, 2'b00, "rd_20");

        // Byte strobes: only bytes 0 and 2 cleared.
        wr(32'h30, 32'hFFFFFFFF, 4'hF, 2'b00, "pre_30");
        wr(32'h30, 32'h00000000, 4'h5, 2'b00, "strb_30");
        rd(32'h30, 32'hFF00FF00, 2'b00, "rd_30");

        // Backpressure on both channels with new requests pending.
        AWADDR = 32'h40; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h10; ARVALID = 1'b1; BREADY = 1'b0; RREADY = 1'b0;
        tick();
        chk("stall_start", {BVALID, RVALID, RDATA}, {2'b11, 32'hDEADBEEF});
        AWADDR = 32'h50; WDATA = 32'h12345678; ARADDR = 32'h20;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", {AWREADY, WREADY, ARREADY, BVALID, BRESP, RVALID, RRESP, RDATA},
                {3'b000, 1'b1, 2'b00, 1'b1, 2'b00, 32'hDEADBEEF});
        end
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
        tick();
        chk("stall_release", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b00111);
        rd(32'h40, 32'hCAFEF00D, 2'b00, "rd_40");

        // Same-edge read and write of one word returns the old data.
        AWADDR = 32'h10; WDATA = 32'h0BADF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h10; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("collide", {BVALID, RVALID, RDATA}, {2'b11, 32'hDEADBEEF});
        tick();
        rd(32'h10, 32'h0BADF00D, 2'b00, "collide_after");

        // Address 0x400 is one past the top of a 1 KiB memory.
        wr(32'h0, 32'h01020304, 4'hF, 2'b00, "pre_0");
`ifdef AXI4_LITE_SLVERR_EN
        wr(32'h400, 32'h55AA55AA, 4'hF, 2'b10, "oor_wr");
        rd(32'h400, 32'h0, 2'b10, "oor_rd");
        rd(32'h0, 32'h01020304, 2'b00, "oor_word0");
`else
        wr(32'h400, 32'h55AA55AA, 4'hF, 2'b00, "wrap_wr");
        rd(32'h400, 32'h55AA55AA, 2'b00, "wrap_rd");
        rd(32'h0, 32'h55AA55AA, 2'b00, "wrap_word0");
`endif

        // Reset with AW held and a read response outstanding.
        AWADDR = 32'h60; AWVALID = 1'b1; ARADDR = 32'h20; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        chk("inflight", {AWREADY, WREADY, RVALID}, 3'b011);
        ARESET = 1'b1;
        tick();
        chk("mid_reset", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}, '0);
        ARESET = 1'b0;
        tick();
        chk("post_reset_rdy", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);
        WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("aw_discarded", {BVALID, AWREADY, WREADY}, 3'b010);
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("post_reset_b", {BVALID, BRESP}, 3'b100);
        tick();
        rd(32'h60, 32'hA5A5A5A5, 2'b00, "rd_60");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
